trackball_emu: RTL and testbench

Digital-joystick-to-trackball emulator that drives the core's `trakball_i` bus. It sits directly upstream of the `centipede` core and converts the four active-high joystick directions into two 4-bit wrapping trackball position counters, so keyboard and pad users can play. Each axis accelerates while a direction is held. The block freezes when the CPU is paused, so no motion is queued during pause.

---
 rtl/trackball_emu.sv | 121 ++++++++++++
 tb/tb_trackball_emu.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/trackball_emu.sv
// Joystick-to-trackball emulator: a shared motion-tick divider drives two
// identical accelerating axis counters that feed the core's trackball bus.

module trackball_axis #(
    parameter int ACCEL_TICKS = 16,
    parameter int MAX_SPEED   = 3,
    parameter bit INC_ON_DIR1 = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       dir1,
    input  logic       dir0,
    output logic [3:0] pos,
    output logic       last_dir,
    output logic       driven
);
    logic [2:0] speed;
    logic [7:0] hold;
    logic       active;
    logic       cont;
    logic       up;
    logic [3:0] amt;
    logic [3:0] next_pos;

    // Opposing inputs cancel, so only an exclusive press drives the axis.
    assign driven   = dir1 ^ dir0;
    assign cont     = active && (dir1 == last_dir);
    assign amt      = cont ? {1'b0, speed} : 4'd1;
    assign up       = INC_ON_DIR1 ? dir1 : ~dir1;
    assign next_pos = up ? pos + amt : pos - amt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= 4'd0;
            last_dir <= 1'b0;
            speed    <= 3'd1;
            hold     <= 8'd0;
            active   <= 1'b0;
        end else if (tick) begin
            if (!driven) begin
                speed  <= 3'd1;
                hold   <= 8'd0;
                active <= 1'b0;
            end else if (!cont) begin
                pos      <= next_pos;
                speed    <= 3'd1;
                hold     <= 8'd0;
                active   <= 1'b1;
                last_dir <= dir1;
            end else begin
                pos <= next_pos;
                if (hold == 8'(ACCEL_TICKS - 1)) begin
                    hold  <= 8'd0;
                    speed <= (speed < 3'(MAX_SPEED)) ? speed + 3'd1 : 3'(MAX_SPEED);
                end else begin
                    hold <= hold + 8'd1;
                end
            end
        end
    end
endmodule

module trackball_emu #(
    parameter int TICK_DIV    = 100000,
    parameter int ACCEL_TICKS = 16,
    parameter int MAX_SPEED   = 3
) (
    input  logic       clk_12,
    input  logic       reset,
    input  logic [3:0] joystick_i,
    input  logic       pause,
    output logic [7:0] trakball_o,
    output logic [1:0] dir_o,
    output logic       step_o
);
    logic [16:0]     div_cnt;
    logic            tick;
    logic [1:0]      dir1;
    logic [1:0]      dir0;
    logic [1:0][3:0] pos;
    logic [1:0]      last_dir;
    logic [1:0]      driven;

    assign tick = !pause && (div_cnt == 17'(TICK_DIV - 1));

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            div_cnt <= 17'd0;
            step_o  <= 1'b0;
        end else begin
            if (!pause) div_cnt <= tick ? 17'd0 : div_cnt + 17'd1;
            step_o <= tick && (|driven);
        end
    end

    // Axis 0 is horizontal (dir1 = left, subtracts); axis 1 is vertical
    // (dir1 = down, adds), matching the dir_o bit meanings.
    assign dir1 = {joystick_i[1], joystick_i[2]};
    assign dir0 = {joystick_i[0], joystick_i[3]};

    for (genvar g = 0; g < 2; g++) begin : g_axis
        trackball_axis #(
            .ACCEL_TICKS(ACCEL_TICKS),
            .MAX_SPEED  (MAX_SPEED),
            .INC_ON_DIR1(g == 1)
        ) u_axis (
            .clk     (clk_12),
            .rst     (reset),
            .tick    (tick),
            .dir1    (dir1[g]),
            .dir0    (dir0[g]),
            .pos     (pos[g]),
            .last_dir(last_dir[g]),
            .driven  (driven[g])
        );
    end

    assign trakball_o = {pos[1], pos[0]};
    assign dir_o      = last_dir;
endmodule

// File: tb/tb_trackball_emu.sv
// Directed bench for trackball_emu with TICK_DIV=4: one motion tick every
// four cycles, inputs driven and outputs sampled on the falling edge.

module tb_trackball_emu;
    localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

    logic       clk_12 = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] joystick_i = 4'd0;
    logic       pause = 1'b0;
    logic [7:0] trakball_o;
    logic [1:0] dir_o;
    logic       step_o;

    int n_chk  = 0;
    int n_fail = 0;
    int nsteps = 0;

    trackball_emu #(.TICK_DIV(4), .ACCEL_TICKS(2), .MAX_SPEED(3)) dut (
        .clk_12    (clk_12),
        .reset     (reset),
        .joystick_i(joystick_i),
        .pause     (pause),
        .trakball_o(trakball_o),
        .dir_o     (dir_o),
        .step_o    (step_o)
    );

    always #5 clk_12 = ~clk_12;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        joystick_i = 4'd0;
        pause      = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge clk_12);
        reset = 1'b0;
    endtask

    // One full divider period; ends on the falling edge after the update.
    task automatic run_tick();
        repeat (4) begin
            @(negedge clk_12);
            nsteps += int'(step_o);
        end
    endtask

    logic [7:0] accel_exp [6] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h0A};

    initial begin
        // Reset, first-tick latency and acceleration on right
        apply_reset();
        check("rst_trak", trakball_o, 8'h00);
        check("rst_step", step_o, 1'b0);
        joystick_i = RIGHT;
        nsteps = 0;
        repeat (3) begin
            @(negedge clk_12);
            nsteps += int'(step_o);
        end
        check("early_step", nsteps, 0);
        check("early_trak", trakball_o, 8'h00);
        @(negedge clk_12);
        check("first_step", step_o, 1'b1);
        check("accel_t0", trakball_o, accel_exp[0]);
        nsteps = 1;
        for (int i = 1; i < 6; i++) begin
            run_tick();
            check($sformatf("accel_t%0d", i), trakball_o, accel_exp[i]);
        end
        check("accel_dir", dir_o[0], 1'b0);
        check("accel_nstep", nsteps, 6);

        // Asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        check("async_trak", trakball_o, 8'h00);
        check("async_dir", dir_o, 2'b00);
        check("async_step", step_o, 1'b0);

        // Vertical wrap
        apply_reset();
        joystick_i = UP;
        run_tick();
        check("wrap_up", trakball_o, 8'hF0);
        check("wrap_up_dir", dir_o[1], 1'b0);
        joystick_i = DOWN;
        run_tick();
        check("wrap_down", trakball_o, 8'h00);
        check("wrap_down_dir", dir_o[1], 1'b1);

        // Reversal and cancel
        apply_reset();
        joystick_i = RIGHT;
        repeat (5) run_tick();
        check("rev_pre", trakball_o, 8'h07);
        joystick_i = LEFT;
        run_tick();
        check("rev_left", trakball_o, 8'h06);
        check("rev_left_dir", dir_o[0], 1'b1);
        joystick_i = LEFT | RIGHT;
        nsteps = 0;
        repeat (3) run_tick();
        check("cancel_trak", trakball_o, 8'h06);
        check("cancel_nstep", nsteps, 0);
        joystick_i = RIGHT;
        run_tick();
        check("rev_right", trakball_o, 8'h07);
        check("rev_right_dir", dir_o[0], 1'b0);

        // Independent axes, single step pulse per tick
        apply_reset();
        joystick_i = RIGHT | DOWN;
        nsteps = 0;
        repeat (3) run_tick();
        check("indep_trak", trakball_o, 8'h33);
        check("indep_nstep", nsteps, 3);

        // Pause mid-period: divider, position and accel state all hold
        apply_reset();
        joystick_i = RIGHT;
        repeat (3) run_tick();
        check("pause_pre", trakball_o, 8'h03);
        repeat (2) @(negedge clk_12);
        pause  = 1'b1;
        nsteps = 0;
        repeat (20) begin
            @(negedge clk_12);
            nsteps += int'(step_o);
        end
        check("pause_nstep", nsteps, 0);
        check("pause_trak", trakball_o, 8'h03);
        pause = 1'b0;
        @(negedge clk_12);
        check("resume_wait", step_o, 1'b0);
        @(negedge clk_12);
        check("resume_step", step_o, 1'b1);
        check("resume_t0", trakball_o, 8'h05);
        run_tick();
        check("resume_t1", trakball_o, 8'h07);
        run_tick();
        check("resume_t2", trakball_o, 8'h0A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
